// File: rtl/mips_defs.sv
// Shared encodings for the MIPS core pipeline.
//   WDSEL_* : write-back data source select codes
//   LT_*    : load extension type codes
package mips_defs;

  localparam logic [1:0] WDSEL_ALU  = 2'd0;
  localparam logic [1:0] WDSEL_MEM  = 2'd1;
  localparam logic [1:0] WDSEL_LINK = 2'd2;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  // Raw W-stage contents; load extension and the WD mux are applied after the register.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  wa;
    logic [1:0]  wdsel;
    logic [2:0]  loadtype;
    logic [1:0]  off;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
  } w_state_t;

endpackage

// File: rtl/load_ext.sv
// Load-data extension (combinational, little-endian byte lanes).
//   raw_i     : raw 32-bit word from data memory
//   off_i     : byte offset (data address [1:0])
//   ld_type_i : load type code (LT_*)
//   ext_o     : extended value for write-back
module load_ext
  import mips_defs::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  ld_type_i,
  output logic [31:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[7:0];
    unique case (off_i)
      2'd0: byte_sel = raw_i[7:0];
      2'd1: byte_sel = raw_i[15:8];
      2'd2: byte_sel = raw_i[23:16];
      2'd3: byte_sel = raw_i[31:24];
      default: byte_sel = raw_i[7:0];
    endcase
    // Halfword selection ignores off_i[0].
    half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  always_comb begin
    ext_o = raw_i;
    case (ld_type_i)
      LT_LB:   ext_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  ext_o = {24'd0, byte_sel};
      LT_LH:   ext_o = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  ext_o = {16'd0, half_sel};
      default: ext_o = raw_i; // LW and undefined codes pass the word through
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// W-stage pipeline register and write-back datapath.
//   Clock, Reset (sync, active-high), Stall, Flush : control
//   M_*      : M-stage results captured into the W stage
//   RegWrite, WA, WD, WPC : register-file write port / forwarding value
//   W_Valid  : W slot holds a real instruction
module mem_wb_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        M_Valid,
  input  logic [31:0] M_PC,
  input  logic        M_RegWrite,
  input  logic [4:0]  M_WA,
  input  logic [1:0]  M_WDSel,
  input  logic [2:0]  M_LoadType,
  input  logic [1:0]  M_ByteOff,
  input  logic [31:0] M_ALUOut,
  input  logic [31:0] M_MemRD,
  output logic        RegWrite,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic [31:0] WPC,
  output logic        W_Valid
);

  w_state_t st_q, st_d;
  w_state_t bubble;
  logic [31:0] load_data;

  always_comb begin
    bubble          = '0;
    bubble.pc       = RESET_PC;
  end

  // Flush beats Stall; Reset is applied in the register itself.
  always_comb begin
    st_d = st_q;
    if (Flush) begin
      st_d = bubble;
    end else if (!Stall) begin
      st_d.valid    = M_Valid;
      st_d.regwrite = M_RegWrite;
      st_d.wa       = M_WA;
      st_d.wdsel    = M_WDSel;
      st_d.loadtype = M_LoadType;
      st_d.off      = M_ByteOff;
      st_d.alu      = M_ALUOut;
      st_d.mem      = M_MemRD;
      st_d.pc       = M_PC;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      st_q <= bubble;
    end else begin
      st_q <= st_d;
    end
  end

  load_ext u_load_ext (
    .raw_i     (st_q.mem),
    .off_i     (st_q.off),
    .ld_type_i (st_q.loadtype),
    .ext_o     (load_data)
  );

  always_comb begin
    WD = 32'd0;
    case (st_q.wdsel)
      WDSEL_ALU:  WD = st_q.alu;
      WDSEL_MEM:  WD = load_data;
      WDSEL_LINK: WD = st_q.pc + LINK_OFFSET;
      default:    WD = 32'd0;
    endcase
  end

  // $0 is hard-wired zero and must never be written.
  assign RegWrite = st_q.valid & st_q.regwrite & (st_q.wa != 5'd0);
  assign WA       = st_q.wa;
  assign WPC      = st_q.pc;
  assign W_Valid  = st_q.valid;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;
  import mips_defs::*;

  logic        Clock = 1'b0;
  logic        Reset, Stall, Flush;
  logic        M_Valid, M_RegWrite;
  logic [31:0] M_PC, M_ALUOut, M_MemRD;
  logic [4:0]  M_WA;
  logic [1:0]  M_WDSel, M_ByteOff;
  logic [2:0]  M_LoadType;
  logic        RegWrite, W_Valid;
  logic [4:0]  WA;
  logic [31:0] WD, WPC;

  int tests = 0;
  int fails = 0;

  mem_wb_stage dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Stall      (Stall),
    .Flush      (Flush),
    .M_Valid    (M_Valid),
    .M_PC       (M_PC),
    .M_RegWrite (M_RegWrite),
    .M_WA       (M_WA),
    .M_WDSel    (M_WDSel),
    .M_LoadType (M_LoadType),
    .M_ByteOff  (M_ByteOff),
    .M_ALUOut   (M_ALUOut),
    .M_MemRD    (M_MemRD),
    .RegWrite   (RegWrite),
    .WA         (WA),
    .WD         (WD),
    .WPC        (WPC),
    .W_Valid    (W_Valid)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] wa, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc);
    M_Valid = v; M_RegWrite = rw; M_WA = wa; M_WDSel = sel; M_LoadType = lt;
    M_ByteOff = off; M_ALUOut = alu; M_MemRD = mem; M_PC = pc;
  endtask

  task automatic chk_bubble(input string tag);
    chk1({tag, ".regwrite"}, RegWrite, 1'b0);
    chk({tag, ".wa"}, {27'd0, WA}, 32'd0);
    chk({tag, ".wd"}, WD, 32'd0);
    chk({tag, ".wpc"}, WPC, 32'h0000_3000);
    chk1({tag, ".valid"}, W_Valid, 1'b0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] off,
                         input logic [31:0] exp);
    drive(1'b1, 1'b1, 5'd10, WDSEL_MEM, lt, off, 32'h1111_1111, 32'h80FF_7F01, 32'h3040);
    step();
    chk(tag, WD, exp);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    step();
    step();
    Reset = 1'b0;

    // Traffic, then reset discards it.
    drive(1'b1, 1'b1, 5'd5, WDSEL_ALU, LT_LW, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'h3100);
    step();
    chk1("traffic.regwrite", RegWrite, 1'b1);
    chk("traffic.wd", WD, 32'hDEAD_BEEF);
    Reset = 1'b1;
    step();
    chk_bubble("reset");
    Reset = 1'b0;

    // ALU capture, one-cycle latency.
    drive(1'b1, 1'b1, 5'd8, WDSEL_ALU, LT_LW, 2'd0, 32'h0000_1234, 32'hFFFF_FFFF, 32'h3004);
    step();
    chk1("alu.regwrite", RegWrite, 1'b1);
    chk("alu.wa", {27'd0, WA}, 32'd8);
    chk("alu.wd", WD, 32'h0000_1234);
    chk("alu.wpc", WPC, 32'h0000_3004);
    chk1("alu.valid", W_Valid, 1'b1);

    // Load extension over MEM = 0x80FF7F01.
    do_load("lb.off1",  LT_LB,  2'd1, 32'h0000_007F);
    do_load("lb.off3",  LT_LB,  2'd3, 32'hFFFF_FF80);
    do_load("lb.off0",  LT_LB,  2'd0, 32'h0000_0001);
    do_load("lb.off2",  LT_LB,  2'd2, 32'hFFFF_FFFF);
    do_load("lbu.off3", LT_LBU, 2'd3, 32'h0000_0080);
    do_load("lbu.off1", LT_LBU, 2'd1, 32'h0000_007F);
    do_load("lh.off2",  LT_LH,  2'd2, 32'hFFFF_80FF);
    do_load("lh.off3",  LT_LH,  2'd3, 32'hFFFF_80FF);
    do_load("lh.off0",  LT_LH,  2'd0, 32'h0000_7F01);
    do_load("lhu.off2", LT_LHU, 2'd2, 32'h0000_80FF);
    do_load("lhu.off1", LT_LHU, 2'd1, 32'h0000_7F01);
    do_load("lw.off1",  LT_LW,  2'd1, 32'h80FF_7F01);
    do_load("undef7",   3'd7,   2'd2, 32'h80FF_7F01);

    // Link write-back, with and without wrap.
    drive(1'b1, 1'b1, 5'd31, WDSEL_LINK, LT_LW, 2'd0, 32'h5555, 32'h6666, 32'hFFFF_FFFC);
    step();
    chk("link.wrap", WD, 32'h0000_0004);
    drive(1'b1, 1'b1, 5'd31, WDSEL_LINK, LT_LW, 2'd0, 32'h5555, 32'h6666, 32'h0000_3008);
    step();
    chk("link.plain", WD, 32'h0000_3010);

    // Reserved select yields zero.
    drive(1'b1, 1'b1, 5'd4, 2'd3, LT_LW, 2'd0, 32'h5555, 32'h6666, 32'h3014);
    step();
    chk("wdsel3.wd", WD, 32'd0);

    // $0 is never written.
    drive(1'b1, 1'b1, 5'd0, WDSEL_ALU, LT_LW, 2'd0, 32'h7777, 32'd0, 32'h3018);
    step();
    chk1("wa0.regwrite", RegWrite, 1'b0);
    chk1("wa0.valid", W_Valid, 1'b1);
    chk("wa0.wd", WD, 32'h7777);

    // Stall holds while inputs change; held load data stays extended the same way.
    drive(1'b1, 1'b1, 5'd9, WDSEL_MEM, LT_LB, 2'd3, 32'hAAAA, 32'h80FF_7F01, 32'h3010);
    step();
    chk("pre_stall.wd", WD, 32'hFFFF_FF80);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd17 + 5'(i), WDSEL_ALU, LT_LBU, 2'(i), 32'h100 + 32'(i),
            32'h0102_0304, 32'h4000 + 32'(i));
      step();
      chk1("stall.regwrite", RegWrite, 1'b1);
      chk("stall.wa", {27'd0, WA}, 32'd9);
      chk("stall.wd", WD, 32'hFFFF_FF80);
      chk("stall.wpc", WPC, 32'h0000_3010);
    end
    Stall = 1'b0;
    drive(1'b1, 1'b1, 5'd12, WDSEL_ALU, LT_LW, 2'd0, 32'hBEEF, 32'd0, 32'h3020);
    step();
    chk("post_stall.wd", WD, 32'h0000_BEEF);
    chk("post_stall.wpc", WPC, 32'h0000_3020);

    // Stall and Flush together: bubble.
    Stall = 1'b1; Flush = 1'b1;
    drive(1'b1, 1'b1, 5'd13, WDSEL_ALU, LT_LW, 2'd0, 32'hCAFE, 32'd0, 32'h3024);
    step();
    chk_bubble("stall_flush");
    Stall = 1'b0; Flush = 1'b0;

    // Invalid M slot never writes but still carries its fields.
    drive(1'b0, 1'b1, 5'd3, WDSEL_ALU, LT_LW, 2'd0, 32'h0000_0055, 32'd0, 32'h3028);
    step();
    chk1("invalid.regwrite", RegWrite, 1'b0);
    chk1("invalid.valid", W_Valid, 1'b0);
    chk("invalid.wa", {27'd0, WA}, 32'd3);
    chk("invalid.wd", WD, 32'h0000_0055);
    chk("invalid.wpc", WPC, 32'h0000_3028);

    // Flush alone.
    drive(1'b1, 1'b1, 5'd7, WDSEL_ALU, LT_LW, 2'd0, 32'h99, 32'd0, 32'h302C);
    Flush = 1'b1;
    step();
    chk_bubble("flush");
    Flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
